// File: rtl/priority_arbiter8.sv
// Eight-requester arbiter for one shared resource: fixed or rotating priority,
// grant hold with an optional hold-time limit, and a one-cycle gap between owners.
module priority_arbiter8 #(
  parameter bit          ROUND_ROBIN = 1'b0,
  parameter int unsigned MAX_HOLD    = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       release_pulse,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam bit               HOLD_LIMITED = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LIMIT   = CNT_W'(MAX_HOLD);

  state_e           state_q, state_d;
  logic [7:0]       grant_q, grant_d;
  logic [2:0]       grant_idx_q, grant_idx_d;
  logic             grant_valid_q, grant_valid_d;
  logic             release_q, release_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [2:0]       last_idx_q, last_idx_d;

  logic [2:0]       search_start;
  logic [3:0]       pick;

  // Descending search from 'start' with wrap 0->7; returns {found, index}.
  // Iterating from the far end lets the nearest set bit overwrite the result.
  function automatic logic [3:0] pick_winner(input logic [7:0] r, input logic [2:0] start);
    logic [3:0] res;
    logic [2:0] cand;
    res = 4'd0;
    for (int k = 7; k >= 0; k--) begin
      cand = start - 3'(k);
      if (r[cand]) begin
        res = {1'b1, cand};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  always_comb begin
    search_start = ROUND_ROBIN ? (last_idx_q - 3'd1) : 3'd7;
    pick         = pick_winner(req, search_start);
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    release_d     = 1'b0;
    timeout_d     = 1'b0;
    hold_cnt_d    = hold_cnt_q;
    last_idx_d    = last_idx_q;
    case (state_q)
      IDLE, GAP: begin
        if (pick[3]) begin
          state_d       = BUSY;
          grant_d       = 8'd1 << pick[2:0];
          grant_idx_d   = pick[2:0];
          grant_valid_d = 1'b1;
          hold_cnt_d    = CNT_W'(1);
          last_idx_d    = pick[2:0];
        end else begin
          state_d       = IDLE;
          grant_d       = 8'd0;
          grant_idx_d   = 3'd0;
          grant_valid_d = 1'b0;
          hold_cnt_d    = '0;
        end
      end
      BUSY: begin
        // A dropped request wins over an expiring hold on the same edge.
        if (!req[grant_idx_q]) begin
          state_d       = GAP;
          grant_d       = 8'd0;
          grant_idx_d   = 3'd0;
          grant_valid_d = 1'b0;
          release_d     = 1'b1;
          timeout_d     = 1'b0;
          hold_cnt_d    = '0;
        end else if (HOLD_LIMITED && (hold_cnt_q == HOLD_LIMIT)) begin
          state_d       = GAP;
          grant_d       = 8'd0;
          grant_idx_d   = 3'd0;
          grant_valid_d = 1'b0;
          release_d     = 1'b1;
          timeout_d     = 1'b1;
          hold_cnt_d    = '0;
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end else begin
          hold_cnt_d = hold_cnt_q;
        end
      end
      default: begin
        state_d       = IDLE;
        grant_d       = 8'd0;
        grant_idx_d   = 3'd0;
        grant_valid_d = 1'b0;
        hold_cnt_d    = '0;
        last_idx_d    = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_q       <= 8'd0;
      grant_idx_q   <= 3'd0;
      grant_valid_q <= 1'b0;
      release_q     <= 1'b0;
      timeout_q     <= 1'b0;
      hold_cnt_q    <= '0;
      last_idx_q    <= 3'd0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      release_q     <= release_d;
      timeout_q     <= timeout_d;
      hold_cnt_q    <= hold_cnt_d;
      last_idx_q    <= last_idx_d;
    end
  end

  assign grant         = grant_q;
  assign grant_idx     = grant_idx_q;
  assign grant_valid   = grant_valid_q;
  assign release_pulse = release_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_priority_arbiter8.sv
// Bench for priority_arbiter8: three configurations (fixed/hold 4, rotating/hold 2,
// fixed/unlimited) checked every cycle against an integer-level reference model.
module tb_priority_arbiter8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [2:0][7:0] req_p;
  logic [2:0][7:0] g_p;
  logic [2:0][2:0] i_p;
  logic [2:0]      gv_p, rp_p, to_p;

  localparam int MH [3] = '{4, 2, 0};
  localparam bit RR [3] = '{1'b0, 1'b1, 1'b0};

  priority_arbiter8 #(.ROUND_ROBIN(1'b0), .MAX_HOLD(4), .CNT_W(8)) dut_fix (
    .clk(clk), .rst_n(rst_n), .req(req_p[0]), .grant(g_p[0]), .grant_idx(i_p[0]),
    .grant_valid(gv_p[0]), .release_pulse(rp_p[0]), .timeout(to_p[0]));

  priority_arbiter8 #(.ROUND_ROBIN(1'b1), .MAX_HOLD(2), .CNT_W(8)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req(req_p[1]), .grant(g_p[1]), .grant_idx(i_p[1]),
    .grant_valid(gv_p[1]), .release_pulse(rp_p[1]), .timeout(to_p[1]));

  priority_arbiter8 #(.ROUND_ROBIN(1'b0), .MAX_HOLD(0), .CNT_W(2)) dut_unl (
    .clk(clk), .rst_n(rst_n), .req(req_p[2]), .grant(g_p[2]), .grant_idx(i_p[2]),
    .grant_valid(gv_p[2]), .release_pulse(rp_p[2]), .timeout(to_p[2]));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: owner index (-1 = nobody), cycles held, last winner, pulse flags.
  int m_owner [3];
  int m_cnt   [3];
  int m_last  [3];
  bit m_rel   [3];
  bit m_to    [3];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input bit rr, input int last, input logic [7:0] r);
    int start;
    start = rr ? (last + 7) % 8 : 7;
    for (int k = 0; k < 8; k++) begin
      if (r[(start - k + 8) % 8]) return (start - k + 8) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_owner[k] = -1; m_cnt[k] = 0; m_last[k] = 0; m_rel[k] = 1'b0; m_to[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input logic [7:0] r);
    int w;
    if (m_owner[k] >= 0) begin
      if (!r[m_owner[k]]) begin
        m_owner[k] = -1; m_rel[k] = 1'b1; m_to[k] = 1'b0;
      end else if (MH[k] != 0 && m_cnt[k] == MH[k]) begin
        m_owner[k] = -1; m_rel[k] = 1'b1; m_to[k] = 1'b1;
      end else begin
        m_cnt[k]++;
      end
    end else begin
      m_rel[k] = 1'b0; m_to[k] = 1'b0;
      w = pick(RR[k], m_last[k], r);
      if (w >= 0) begin
        m_owner[k] = w; m_cnt[k] = 1; m_last[k] = w;
      end
    end
  endtask

  function automatic logic [13:0] exp_vec(input int k);
    logic [7:0] g;
    logic [2:0] ix;
    g  = (m_owner[k] >= 0) ? (8'd1 << m_owner[k]) : 8'd0;
    ix = (m_owner[k] >= 0) ? 3'(m_owner[k]) : 3'd0;
    return {g, ix, (m_owner[k] >= 0), m_rel[k], m_to[k]};
  endfunction

  task automatic check_all();
    bit ok;
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("out%0d", k), {18'd0, g_p[k], i_p[k], gv_p[k], rp_p[k], to_p[k]},
               {18'd0, exp_vec(k)});
      ok = $onehot0(g_p[k]) && (gv_p[k] == (|g_p[k])) &&
           (gv_p[k] ? (g_p[k] == (8'd1 << i_p[k])) : (i_p[k] == 3'd0));
      check_eq($sformatf("inv%0d", k), {31'd0, ok}, 32'd1);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k, req_p[k]);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    req_p = '0;
    rst_n = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Grant latency, release on drop, then the next requester after the gap.
    req_p[0] = 8'h05;
    cycle();
    check_eq("t1_grant", {24'd0, g_p[0]}, 32'h04);
    check_eq("t1_idx", {29'd0, i_p[0]}, 32'd2);
    req_p[0] = 8'h01;
    cycle();
    check_eq("t1_rel", {29'd0, g_p[0] != 8'd0, rp_p[0], to_p[0]}, 32'b010);
    cycle();
    check_eq("t1_next", {24'd0, g_p[0]}, 32'h01);
    req_p[0] = 8'h00;
    cycle();
    cycle();

    // Rotating priority with all requesting: 7,7,gap,6,6,gap,...,0,0,gap,7.
    req_p[1] = 8'hFF;
    for (int n = 0; n < 25; n++) begin
      cycle();
      if (n % 3 == 2) begin
        check_eq("t3_gap", {31'd0, gv_p[1]}, 32'd0);
      end else begin
        check_eq("t3_idx", {28'd0, gv_p[1], i_p[1]}, {28'd0, 1'b1, 3'(7 - (n / 3) % 8)});
      end
    end
    req_p[1] = 8'h00;
    cycle();
    cycle();

    // Fixed mode hold limit: four grant cycles then a timed-out gap, repeating.
    req_p[0] = 8'h80;
    for (int n = 0; n < 10; n++) begin
      cycle();
      if (n % 5 == 4) begin
        check_eq("t2_gap", {22'd0, g_p[0], rp_p[0], to_p[0]}, {22'd0, 8'h00, 2'b11});
      end else begin
        check_eq("t2_hold", {24'd0, g_p[0]}, 32'h80);
      end
    end

    // Drop on the same edge as hold expiry reports a plain release.
    repeat (4) cycle();
    req_p[0] = 8'h00;
    cycle();
    check_eq("t6_rel", {30'd0, rp_p[0], to_p[0]}, 32'b10);
    cycle();
    check_eq("t6_once", {31'd0, rp_p[0]}, 32'd0);

    // Other requests never preempt the owner.
    req_p[0] = 8'h08;
    cycle();
    req_p[0] = 8'hFF;
    for (int n = 0; n < 3; n++) begin
      cycle();
      check_eq("t4_keep", {24'd0, g_p[0]}, 32'h08);
    end
    cycle();
    cycle();

    // Asynchronous reset between edges while busy.
    req_p[1] = 8'hFF;
    cycle();
    cycle();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("t5_zero%0d", k), {18'd0, g_p[k], i_p[k], gv_p[k], rp_p[k], to_p[k]}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req_p = '0;
    req_p[1] = 8'h10;
    cycle();
    check_eq("t5_grant", {24'd0, g_p[1]}, 32'h10);
    req_p[1] = 8'h00;
    cycle();
    cycle();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 3; k++) begin
        case ($urandom_range(0, 11))
          0, 1: req_p[k] = 8'($urandom);
          2:    req_p[k] = 8'h00;
          3:    if (m_owner[k] >= 0) req_p[k][m_owner[k]] = 1'b0;
          4:    req_p[k][$urandom_range(0, 7)] = 1'b1;
          5:    req_p[k] = 8'hFF;
          default: req_p[k] = req_p[k];
        endcase
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
